// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
// Imported by the picker and the arbiter top.
package rr_arbiter_4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: rotate by ptr, fixed-priority
// encode, then add ptr back to recover the absolute winner index.
module rr_pick4
  import rr_arbiter_4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   enc;

  always_comb begin
    dbl = {req, req};
    rot = N_REQ'(dbl >> ptr);
    enc = '0;
    priority case (1'b1)
      rot[0]:  enc = 2'd0;
      rot[1]:  enc = 2'd1;
      rot[2]:  enc = 2'd2;
      rot[3]:  enc = 2'd3;
      default: enc = 2'd0;
    endcase
    found = |req;
    idx   = enc + ptr;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with hold timeout.
// One idle cycle always separates consecutive grants.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic             timeout
);

  localparam bit TO_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    TO_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               to_q, to_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               own_req;
  logic               hit;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    own_req = req[idx_q];
    hit     = TO_EN && (cnt_q == HOLD_LAST);
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          gnt_d   = N_REQ'(1) << pick_idx;
          idx_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (done || !own_req || hit) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = idx_q + IDX_W'(1);
          // flag only a release forced purely by the hold limit
          to_d    = hit && !done && own_req;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign busy    = (state_q == BUSY);
  assign timeout = to_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: directed vectors queue
// expected outputs; a monitor pops and compares each cycle.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;

  typedef struct {
    string      name;
    logic [3:0] g;
    logic [1:0] i;
    logic       b;
    logic       t;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  rr_arbiter_4 #(
    .MAX_HOLD (8),
    .CNT_W    (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] eg,
                       input logic [1:0] ei, input logic eb,
                       input logic et);
    n_vec++;
    if (gnt !== eg || gnt_idx !== ei || busy !== eb ||
        timeout !== et || busy !== (|gnt)) begin
      n_miss++;
      $display("FAIL %s: got gnt=%b idx=%0d busy=%b to=%b, want gnt=%b idx=%0d busy=%b to=%b",
               name, gnt, gnt_idx, busy, timeout, eg, ei, eb, et);
    end
  endtask

  // monitor: one expectation per clock, sampled on the falling edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, e.g, e.i, e.b, e.t);
    end
  end

  task automatic step(input string name, input logic [3:0] r,
                      input logic d, input logic [3:0] eg,
                      input logic [1:0] ei, input logic eb,
                      input logic et);
    exp_t e;
    @(negedge clk);
    #1;
    req  = r;
    done = d;
    e.name = name;
    e.g = eg;
    e.i = ei;
    e.b = eb;
    e.t = et;
    sb.push_back(e);
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check(name, 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    req   = '0;
    done  = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #12 check("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // single request
    step("single_gnt",  4'b0010, 0, 4'b0010, 2'd1, 1, 0);
    step("single_done", 4'b0010, 1, 4'b0000, 2'd1, 0, 0);
    step("single_idle", 4'b0000, 0, 4'b0000, 2'd1, 0, 0);

    pulse_reset("reset_again");

    // rotation with all requesters active
    step("rot_g0", 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
    step("rot_r0", 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
    step("rot_g1", 4'b1111, 0, 4'b0010, 2'd1, 1, 0);
    step("rot_r1", 4'b1111, 1, 4'b0000, 2'd1, 0, 0);
    step("rot_g2", 4'b1111, 0, 4'b0100, 2'd2, 1, 0);
    step("rot_r2", 4'b1111, 1, 4'b0000, 2'd2, 0, 0);
    step("rot_g3", 4'b1111, 0, 4'b1000, 2'd3, 1, 0);
    step("rot_r3", 4'b1111, 1, 4'b0000, 2'd3, 0, 0);

    // pointer wrapped to 0: requester 0 beats 3
    step("wrap_g0", 4'b1001, 0, 4'b0001, 2'd0, 1, 0);
    step("wrap_r0", 4'b1001, 1, 4'b0000, 2'd0, 0, 0);

    // hold timeout: eight granted cycles, then forced release
    step("to_gnt", 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    for (int k = 1; k < 8; k++)
      step("to_hold", 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    step("to_fire",  4'b0100, 0, 4'b0000, 2'd2, 0, 1);
    step("to_regnt", 4'b0100, 0, 4'b0100, 2'd2, 1, 0);

    // done coincides with the timeout cycle: normal release
    for (int k = 1; k < 8; k++)
      step("dt_hold", 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    step("dt_rel", 4'b0100, 1, 4'b0000, 2'd2, 0, 0);

    // owner 1 drops as requester 2 rises
    step("drop_g1",  4'b0010, 0, 4'b0010, 2'd1, 1, 0);
    step("drop_rel", 4'b0100, 0, 4'b0000, 2'd1, 0, 0);
    step("drop_g2",  4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    step("drop_r2",  4'b0000, 0, 4'b0000, 2'd2, 0, 0);

    // asynchronous reset while requester 3 owns the grant
    step("ar_g3", 4'b1000, 0, 4'b1000, 2'd3, 1, 0);
    pulse_reset("async_reset");
    step("ar_first", 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
    step("ar_rel",   4'b1111, 1, 4'b0000, 2'd0, 0, 0);
    step("ar_idle",  4'b0000, 0, 4'b0000, 2'd0, 0, 0);

    for (int k = 0; k < 5 && sb.size() > 0; k++)
      @(negedge clk);
    if (sb.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
